// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps an upstream byte stream with preamble/SFD,
// pads short frames, appends the IEEE 802.3 CRC-32 FCS and holds off for the IFG.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_LEN      = 12
) (
  input  logic        gtx_clk,
  input  logic        sys_rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        tx_en,
  output logic [7:0]  txd,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [15:0] MIN_W = 16'(MIN_FRAME);
  localparam logic [7:0]  PRE_W = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_W = 8'(IFG_LEN);

  state_t      state;
  logic [31:0] crc;
  logic [15:0] byte_cnt;
  logic [7:0]  cyc_cnt;
  logic        bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A bad frame sends the raw remainder so the receiver's FCS check fails.
  function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic is_bad,
                                          input logic [1:0] idx);
    logic [31:0] f;
    f = is_bad ? c : ~c;
    f = f >> {idx, 3'b000};
    return f[7:0];
  endfunction

  always_ff @(posedge gtx_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      tx_en     <= 1'b0;
      txd       <= 8'h00;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      frame_cnt <= 16'd0;
      crc       <= 32'hFFFF_FFFF;
      byte_cnt  <= 16'd0;
      cyc_cnt   <= 8'd0;
      bad       <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state   <= S_PRE;
            tx_en   <= 1'b1;
            txd     <= 8'h55;
            busy    <= 1'b1;
            cyc_cnt <= 8'd1;
          end
        end
        S_PRE: begin
          if (cyc_cnt == PRE_W) begin
            state    <= S_SFD;
            txd      <= 8'hD5;
            in_ready <= 1'b1;
            crc      <= 32'hFFFF_FFFF;
            byte_cnt <= 16'd0;
            bad      <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        // While in_ready is high a byte (or an underrun filler) is taken every
        // cycle; once it drops, the shared tail decides between PAD and FCS.
        S_SFD, S_DATA, S_PAD: begin
          if (in_ready) begin
            state    <= S_DATA;
            byte_cnt <= sat_inc(byte_cnt);
            if (in_valid) begin
              txd      <= in_data;
              crc      <= crc_byte(crc, in_data);
              in_ready <= ~in_last;
            end else begin
              txd      <= 8'h00;
              crc      <= crc_byte(crc, 8'h00);
              in_ready <= 1'b0;
              underrun <= 1'b1;
              bad      <= 1'b1;
            end
          end else if (byte_cnt < MIN_W) begin
            state    <= S_PAD;
            txd      <= 8'h00;
            crc      <= crc_byte(crc, 8'h00);
            byte_cnt <= sat_inc(byte_cnt);
          end else begin
            state   <= S_FCS;
            txd     <= fcs_byte(crc, bad, 2'd0);
            cyc_cnt <= 8'd1;
          end
        end
        S_FCS: begin
          if (cyc_cnt == 8'd4) begin
            state   <= S_IFG;
            tx_en   <= 1'b0;
            txd     <= 8'h00;
            cyc_cnt <= 8'd1;
            if (!bad) frame_cnt <= frame_cnt + 16'd1;
          end else begin
            txd     <= fcs_byte(crc, bad, cyc_cnt[1:0]);
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        S_IFG: begin
          if (cyc_cnt == IFG_W) begin
            if (in_valid) begin
              state   <= S_PRE;
              tx_en   <= 1'b1;
              txd     <= 8'h55;
              cyc_cnt <= 8'd1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: table of single-frame vectors, hand-written corner
// sequences and random frames, all checked against a table-based CRC frame model.
module tb_gmii_tx_framer;

  typedef logic [7:0] bq_t[$];
  typedef bit         bitq_t[$];

  typedef struct {
    string nm;
    bit    sel;
    bit    fixed;
    int    len;
    bit    bad;
    int    exp_txen;
    int    exp_cnt;
    int    exp_ur;
  } vec_t;

  logic        gtx_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        sel = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;

  logic        iv0, iv1;
  logic        ir0, te0, by0, ur0, ir1, te1, by1, ur1;
  logic [7:0]  td0, td1;
  logic [15:0] fc0, fc1;
  logic        m_in_ready, m_tx_en, m_busy, m_underrun;
  logic [7:0]  m_txd;
  logic [15:0] m_frame_cnt;

  int checks = 0;
  int fails  = 0;
  int ur_cnt = 0;
  int busy_viol = 0;
  logic [7:0] cap_q[$];
  int cap_len[$];
  int cap_gap[$];
  logic [31:0] crc_tbl[256];

  always #4 gtx_clk = ~gtx_clk;

  assign iv0 = in_valid & ~sel;
  assign iv1 = in_valid & sel;
  assign m_in_ready  = sel ? ir1 : ir0;
  assign m_tx_en     = sel ? te1 : te0;
  assign m_txd       = sel ? td1 : td0;
  assign m_busy      = sel ? by1 : by0;
  assign m_underrun  = sel ? ur1 : ur0;
  assign m_frame_cnt = sel ? fc1 : fc0;

  gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(0), .IFG_LEN(12)) dut0 (
    .gtx_clk(gtx_clk), .sys_rst(sys_rst), .in_valid(iv0), .in_data(in_data),
    .in_last(in_last), .in_ready(ir0), .tx_en(te0), .txd(td0), .busy(by0),
    .underrun(ur0), .frame_cnt(fc0));

  gmii_tx_framer dut1 (
    .gtx_clk(gtx_clk), .sys_rst(sys_rst), .in_valid(iv1), .in_data(in_data),
    .in_last(in_last), .in_ready(ir1), .tx_en(te1), .txd(td1), .busy(by1),
    .underrun(ur1), .frame_cnt(fc1));

  // Monitor: collects each contiguous tx_en burst and the idle gap before it.
  initial begin
    bit inf;
    int gap;
    int cur;
    inf = 1'b0; gap = 0; cur = 0;
    forever begin
      @(negedge gtx_clk);
      if (m_underrun === 1'b1) ur_cnt++;
      if (m_tx_en === 1'b1 && m_busy !== 1'b1) busy_viol++;
      if (m_tx_en === 1'b1) begin
        if (!inf) begin
          inf = 1'b1; cur = 0;
          cap_gap.push_back(gap);
        end
        cap_q.push_back(m_txd);
        cur++;
      end else begin
        if (inf) begin
          inf = 1'b0;
          cap_len.push_back(cur);
          gap = 0;
        end
        gap++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    sys_rst = 1'b1;
    repeat (2) @(posedge gtx_clk);
    #1 sys_rst = 1'b0;
    @(negedge gtx_clk);
    @(posedge gtx_clk);
    #1;
  endtask

  task automatic send_stream(input string nm, input bq_t d, input bitq_t l);
    int i;
    int budget;
    bit rdy;
    i = 0; budget = 0;
    if (d.size() == 0) return;
    in_valid = 1'b1; in_data = d[0]; in_last = l[0];
    while (i < d.size()) begin
      @(negedge gtx_clk);
      rdy = (m_in_ready === 1'b1);
      @(posedge gtx_clk);
      #1;
      if (rdy) begin
        i++;
        if (i < d.size()) begin
          in_data = d[i]; in_last = l[i];
        end
      end
      budget++;
      if (budget > 5000) begin
        fail_to(nm);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge gtx_clk);
    while (m_busy !== 1'b0 && n < 4000) begin
      @(negedge gtx_clk);
      n++;
    end
    if (n >= 4000) fail_to(nm);
    @(posedge gtx_clk);
    #1;
  endtask

  function automatic int frame_off(input int fidx);
    int o;
    o = 0;
    for (int i = 0; i < fidx; i++) o += cap_len[i];
    return o;
  endfunction

  // Reference frame: preamble, SFD, body padded to minf, FCS LSB-first.
  function automatic void build_exp(input bq_t pl, input bit bad, input int minf, output bq_t e);
    bq_t body;
    logic [31:0] c;
    logic [7:0] idx;
    body = pl;
    if (bad) body.push_back(8'h00);
    while (body.size() < minf) body.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body[k]) begin
      idx = c[7:0] ^ body[k];
      c = crc_tbl[idx] ^ (c >> 8);
    end
    if (!bad) c = ~c;
    e = {};
    for (int k = 0; k < 7; k++) e.push_back(8'h55);
    e.push_back(8'hD5);
    foreach (body[k]) e.push_back(body[k]);
    for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
  endfunction

  task automatic check_frame(input string nm, input int fidx, input bq_t e);
    int off;
    int len;
    int diff;
    checks++;
    if (fidx >= cap_len.size()) begin
      fails++;
      $display("FAIL %s: frame %0d not seen, got %0d frames", nm, fidx, cap_len.size());
      return;
    end
    off = frame_off(fidx);
    len = cap_len[fidx];
    diff = -1;
    if (len == e.size()) begin
      for (int k = 0; k < len; k++) begin
        if (cap_q[off+k] !== e[k]) begin
          diff = k;
          break;
        end
      end
    end
    if (len != e.size()) begin
      fails++;
      $display("FAIL %s: frame length got %0d required %0d", nm, len, e.size());
    end else if (diff >= 0) begin
      fails++;
      $display("FAIL %s: byte %0d got %02h required %02h", nm, diff, cap_q[off+diff], e[diff]);
    end
  endtask

  task automatic set_vec(output vec_t v, input string nm, input bit s, input bit fx,
                         input int len, input bit bad, input int txen, input int cnt, input int ur);
    v.nm = nm; v.sel = s; v.fixed = fx; v.len = len; v.bad = bad;
    v.exp_txen = txen; v.exp_cnt = cnt; v.exp_ur = ur;
  endtask

  initial begin
    vec_t vt[7];
    bq_t pl, e, exp_all;
    bitq_t ls;
    int exp_len[$];
    int fb, ub, n, k, off, eo, nfr;
    bit rdy;
    logic [31:0] fcs_word;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] r;
      r = 32'(i);
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      crc_tbl[i] = r;
    end

    set_vec(vt[0], "crc_vec",   0, 1,  9, 0, 21, 1, 0);
    set_vec(vt[1], "pad14",     1, 0, 14, 0, 72, 1, 0);
    set_vec(vt[2], "len60",     1, 0, 60, 0, 72, 1, 0);
    set_vec(vt[3], "len61",     1, 0, 61, 0, 73, 1, 0);
    set_vec(vt[4], "ur20",      1, 0, 20, 1, 72, 0, 1);
    set_vec(vt[5], "one_byte",  0, 0,  1, 0, 13, 1, 0);
    set_vec(vt[6], "ur5_nopad", 0, 0,  5, 1, 18, 0, 1);

    // Reset values on both instances
    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk($sformatf("rst_tx_en_%0d", s), m_tx_en, 0);
      chk($sformatf("rst_txd_%0d", s), m_txd, 0);
      chk($sformatf("rst_in_ready_%0d", s), m_in_ready, 0);
      chk($sformatf("rst_busy_%0d", s), m_busy, 0);
      chk($sformatf("rst_underrun_%0d", s), m_underrun, 0);
      chk($sformatf("rst_frame_cnt_%0d", s), m_frame_cnt, 0);
    end

    // Table-driven single-frame vectors
    for (int v = 0; v < 7; v++) begin
      sel = vt[v].sel;
      do_reset();
      fb = cap_len.size();
      ub = ur_cnt;
      pl = {}; ls = {};
      for (int j = 0; j < vt[v].len; j++) begin
        pl.push_back(vt[v].fixed ? 8'(8'h31 + j) : 8'($urandom));
        ls.push_back(!vt[v].bad && (j == vt[v].len - 1));
      end
      send_stream({vt[v].nm, "_send"}, pl, ls);
      wait_idle({vt[v].nm, "_idle"});
      chk({vt[v].nm, "_frames"}, cap_len.size() - fb, 1);
      if (cap_len.size() > fb) chk({vt[v].nm, "_txen_cycles"}, cap_len[fb], vt[v].exp_txen);
      build_exp(pl, vt[v].bad, vt[v].sel ? 60 : 0, e);
      check_frame({vt[v].nm, "_bytes"}, fb, e);
      chk({vt[v].nm, "_frame_cnt"}, m_frame_cnt, vt[v].exp_cnt);
      chk({vt[v].nm, "_underruns"}, ur_cnt - ub, vt[v].exp_ur);
      if (vt[v].fixed && cap_len.size() > fb && cap_len[fb] == 21) begin
        off = frame_off(fb);
        fcs_word = {cap_q[off+20], cap_q[off+19], cap_q[off+18], cap_q[off+17]};
        chk("crc_vec_fcs", fcs_word, 32'hCBF4_3926);
      end
    end

    // IFG: busy stays high exactly IFG_LEN cycles after tx_en falls
    sel = 1'b1;
    do_reset();
    pl = {}; ls = {};
    for (int j = 0; j < 14; j++) begin
      pl.push_back(8'($urandom)); ls.push_back(j == 13);
    end
    send_stream("ifg_send", pl, ls);
    n = 0;
    @(negedge gtx_clk);
    while (m_tx_en !== 1'b0 && n < 500) begin
      @(negedge gtx_clk);
      n++;
    end
    if (n >= 500) fail_to("ifg_txen_fall");
    k = 0;
    while (m_busy === 1'b1 && k < 100) begin
      k++;
      @(negedge gtx_clk);
    end
    chk("ifg_busy_cycles", k, 12);
    @(posedge gtx_clk);
    #1;

    // Back-to-back: two 64-byte frames with in_valid held high
    do_reset();
    fb = cap_len.size();
    pl = {}; ls = {};
    for (int j = 0; j < 128; j++) begin
      pl.push_back(8'($urandom)); ls.push_back(j == 63 || j == 127);
    end
    send_stream("b2b_send", pl, ls);
    wait_idle("b2b_idle");
    chk("b2b_frames", cap_len.size() - fb, 2);
    build_exp(pl[0:63], 1'b0, 60, e);
    check_frame("b2b_frame1", fb, e);
    build_exp(pl[64:127], 1'b0, 60, e);
    check_frame("b2b_frame2", fb + 1, e);
    if (cap_gap.size() > fb + 1) chk("b2b_gap", cap_gap[fb+1], 12);
    chk("b2b_frame_cnt", m_frame_cnt, 2);

    // Reset asserted mid-frame, then a clean 60-byte frame
    do_reset();
    in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b0;
    n = 0; rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge gtx_clk);
      rdy = (m_in_ready === 1'b1);
      n++;
    end
    if (!rdy) fail_to("rst_mid_ready");
    repeat (6) @(posedge gtx_clk);
    #1 sys_rst = 1'b1;
    @(posedge gtx_clk);
    #1;
    chk("rst_mid_tx_en", m_tx_en, 0);
    chk("rst_mid_busy", m_busy, 0);
    chk("rst_mid_in_ready", m_in_ready, 0);
    sys_rst = 1'b0; in_valid = 1'b0;
    @(negedge gtx_clk);
    @(posedge gtx_clk);
    #1;
    fb = cap_len.size();
    pl = {}; ls = {};
    for (int j = 0; j < 60; j++) begin
      pl.push_back(8'($urandom)); ls.push_back(j == 59);
    end
    send_stream("rst_after_send", pl, ls);
    wait_idle("rst_after_idle");
    chk("rst_after_frames", cap_len.size() - fb, 1);
    build_exp(pl, 1'b0, 60, e);
    check_frame("rst_after_bytes", fb, e);
    chk("rst_after_frame_cnt", m_frame_cnt, 1);

    // Random frames with random idle spacing, checked against the model
    do_reset();
    fb = cap_len.size();
    exp_all = {}; exp_len = {};
    nfr = 6;
    for (int f = 0; f < nfr; f++) begin
      n = $urandom_range(1, 90);
      pl = {}; ls = {};
      for (int j = 0; j < n; j++) begin
        pl.push_back(8'($urandom)); ls.push_back(j == n - 1);
      end
      build_exp(pl, 1'b0, 60, e);
      foreach (e[j]) exp_all.push_back(e[j]);
      exp_len.push_back(e.size());
      send_stream($sformatf("rand_send_%0d", f), pl, ls);
      repeat ($urandom_range(0, 4)) @(posedge gtx_clk);
      #1;
    end
    wait_idle("rand_idle");
    chk("rand_frames", cap_len.size() - fb, nfr);
    eo = 0;
    for (int f = 0; f < nfr; f++) begin
      e = exp_all[eo : eo + exp_len[f] - 1];
      check_frame($sformatf("rand_frame_%0d", f), fb + f, e);
      eo += exp_len[f];
    end
    chk("rand_frame_cnt", m_frame_cnt, nfr);

    // frame_cnt wrap from 0xFFFF
    do_reset();
    force dut1.frame_cnt = 16'hFFFF;
    @(posedge gtx_clk);
    #1;
    release dut1.frame_cnt;
    pl = {}; ls = {};
    for (int j = 0; j < 60; j++) begin
      pl.push_back(8'($urandom)); ls.push_back(j == 59);
    end
    send_stream("wrap_send", pl, ls);
    wait_idle("wrap_idle");
    chk("wrap_frame_cnt", m_frame_cnt, 0);

    chk("busy_with_tx_en", busy_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
